// File: rtl/mem_port_arbiter.sv
// Arbitrates instruction fetch and data accesses onto one multi-cycle memory port,
// with starvation protection for fetches and a watchdog for a memory that never acks.
module mem_port_arbiter #(
    parameter int ADDR_W        = 32,
    parameter int DATA_W        = 32,
    parameter int MAX_DM_STREAK = 4,
    parameter int TIMEOUT       = 255
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              if_req_i,
    input  logic [ADDR_W-1:0] if_addr_i,
    output logic [DATA_W-1:0] if_rdata_o,
    output logic              if_ack_o,
    input  logic              dm_req_i,
    input  logic              dm_we_i,
    input  logic [ADDR_W-1:0] dm_addr_i,
    input  logic [DATA_W-1:0] dm_wdata_i,
    output logic [DATA_W-1:0] dm_rdata_o,
    output logic              dm_ack_o,
    output logic              mem_req_o,
    output logic              mem_we_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [DATA_W-1:0] mem_wdata_o,
    input  logic [DATA_W-1:0] mem_rdata_i,
    input  logic              mem_ack_i,
    output logic              stall_o,
    output logic              err_o
);

    localparam int STREAK_W = $clog2(MAX_DM_STREAK + 1);
    localparam logic [STREAK_W-1:0] STREAK_MAX = STREAK_W'(MAX_DM_STREAK);
    localparam logic [7:0] WDOG_LAST = 8'(TIMEOUT - 1);

    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] IF_BUSY = 2'd1;
    localparam logic [1:0] DM_BUSY = 2'd2;

    logic [1:0]          state_reg;
    logic [STREAK_W-1:0] streak_reg, streak_next;
    logic [7:0]          wdog_reg;
    logic                mem_req_reg, mem_we_reg;
    logic [ADDR_W-1:0]   mem_addr_reg;
    logic [DATA_W-1:0]   mem_wdata_reg;
    logic [DATA_W-1:0]   if_rdata_reg, dm_rdata_reg;
    logic                if_ack_reg, dm_ack_reg, err_reg;

    logic can_grant, grant_if, grant_dm, wdog_expire, finish;

    // The ack cycle is an enforced idle cycle: no grant is issued while an ack is out.
    always_comb begin
        can_grant   = (state_reg == IDLE) && !if_ack_reg && !dm_ack_reg;
        grant_if    = can_grant && if_req_i && (!dm_req_i || (streak_reg == STREAK_MAX));
        grant_dm    = can_grant && dm_req_i && !grant_if;
        wdog_expire = (wdog_reg == WDOG_LAST) && !mem_ack_i;
        finish      = ((state_reg == IF_BUSY) || (state_reg == DM_BUSY)) &&
                      (mem_ack_i || wdog_expire);
    end

    always_comb begin
        streak_next = streak_reg;
        if (grant_if) begin
            streak_next = '0;
        end else if (grant_dm) begin
            if (!if_req_i)
                streak_next = '0;
            else if (streak_reg != STREAK_MAX)
                streak_next = streak_reg + STREAK_W'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_reg     <= IDLE;
            streak_reg    <= '0;
            wdog_reg      <= '0;
            mem_req_reg   <= 1'b0;
            mem_we_reg    <= 1'b0;
            mem_addr_reg  <= '0;
            mem_wdata_reg <= '0;
            if_rdata_reg  <= '0;
            dm_rdata_reg  <= '0;
            if_ack_reg    <= 1'b0;
            dm_ack_reg    <= 1'b0;
            err_reg       <= 1'b0;
        end else begin
            if_ack_reg <= 1'b0;
            dm_ack_reg <= 1'b0;
            streak_reg <= streak_next;
            case (state_reg)
                IDLE: begin
                    wdog_reg <= '0;
                    if (grant_if) begin
                        state_reg     <= IF_BUSY;
                        mem_req_reg   <= 1'b1;
                        mem_we_reg    <= 1'b0;
                        mem_addr_reg  <= if_addr_i;
                        mem_wdata_reg <= '0;
                    end else if (grant_dm) begin
                        state_reg     <= DM_BUSY;
                        mem_req_reg   <= 1'b1;
                        mem_we_reg    <= dm_we_i;
                        mem_addr_reg  <= dm_addr_i;
                        mem_wdata_reg <= dm_wdata_i;
                    end
                end
                IF_BUSY, DM_BUSY: begin
                    if (finish) begin
                        state_reg   <= IDLE;
                        mem_req_reg <= 1'b0;
                        wdog_reg    <= '0;
                        if (!mem_ack_i)
                            err_reg <= 1'b1;
                        // A timed-out or store transaction returns zero data.
                        if (state_reg == IF_BUSY) begin
                            if_ack_reg   <= 1'b1;
                            if_rdata_reg <= mem_ack_i ? mem_rdata_i : '0;
                        end else begin
                            dm_ack_reg   <= 1'b1;
                            dm_rdata_reg <= (mem_ack_i && !mem_we_reg) ? mem_rdata_i : '0;
                        end
                    end else begin
                        wdog_reg <= wdog_reg + 8'd1;
                    end
                end
                default: begin
                    state_reg   <= IDLE;
                    mem_req_reg <= 1'b0;
                end
            endcase
        end
    end

    assign if_rdata_o  = if_rdata_reg;
    assign if_ack_o    = if_ack_reg;
    assign dm_rdata_o  = dm_rdata_reg;
    assign dm_ack_o    = dm_ack_reg;
    assign mem_req_o   = mem_req_reg;
    assign mem_we_o    = mem_we_reg;
    assign mem_addr_o  = mem_addr_reg;
    assign mem_wdata_o = mem_wdata_reg;
    assign err_o       = err_reg;
    assign stall_o     = (if_req_i & ~if_ack_reg) | (dm_req_i & ~dm_ack_reg);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: inputs change and outputs are sampled on the
// falling edge, the DUT updates on the rising edge.
module tb_mem_port_arbiter;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        if_req_i;
    logic [31:0] if_addr_i;
    logic [31:0] if_rdata_o;
    logic        if_ack_o;
    logic        dm_req_i;
    logic        dm_we_i;
    logic [31:0] dm_addr_i;
    logic [31:0] dm_wdata_i;
    logic [31:0] dm_rdata_o;
    logic        dm_ack_o;
    logic        mem_req_o;
    logic        mem_we_o;
    logic [31:0] mem_addr_o;
    logic [31:0] mem_wdata_o;
    logic [31:0] mem_rdata_i;
    logic        mem_ack_i;
    logic        stall_o;
    logic        err_o;

    int tests_run    = 0;
    int tests_failed = 0;

    always #5 clk_i = ~clk_i;

    mem_port_arbiter #(
        .ADDR_W(32), .DATA_W(32), .MAX_DM_STREAK(4), .TIMEOUT(255)
    ) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .if_req_i(if_req_i), .if_addr_i(if_addr_i),
        .if_rdata_o(if_rdata_o), .if_ack_o(if_ack_o),
        .dm_req_i(dm_req_i), .dm_we_i(dm_we_i), .dm_addr_i(dm_addr_i),
        .dm_wdata_i(dm_wdata_i), .dm_rdata_o(dm_rdata_o), .dm_ack_o(dm_ack_o),
        .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o),
        .mem_wdata_o(mem_wdata_o), .mem_rdata_i(mem_rdata_i), .mem_ack_i(mem_ack_i),
        .stall_o(stall_o), .err_o(err_o)
    );

    task automatic test_reset();
        rst_i = 1'b1; if_req_i = 0; if_addr_i = 0; dm_req_i = 0; dm_we_i = 0;
        dm_addr_i = 0; dm_wdata_i = 0; mem_rdata_i = 0; mem_ack_i = 0;
        repeat (3) @(negedge clk_i);
        rst_i = 1'b0;
        @(negedge clk_i);
        tests_run++;
        if ({mem_req_o, mem_we_o, if_ack_o, dm_ack_o, err_o, stall_o} !== 6'b0) begin
            tests_failed++;
            $display("FAIL reset_ctrl: got %b expected 000000",
                     {mem_req_o, mem_we_o, if_ack_o, dm_ack_o, err_o, stall_o});
        end
        tests_run++;
        if ({mem_addr_o, mem_wdata_o, if_rdata_o, dm_rdata_o} !== 128'b0) begin
            tests_failed++;
            $display("FAIL reset_data: addr=%h wdata=%h if_rdata=%h dm_rdata=%h expected all 0",
                     mem_addr_o, mem_wdata_o, if_rdata_o, dm_rdata_o);
        end
        $display("[TB] reset done");
    endtask

    task automatic test_fetch();
        if_req_i = 1; if_addr_i = 32'h10;
        @(negedge clk_i);
        tests_run++;
        if ({mem_req_o, mem_we_o, stall_o} !== 3'b101 || mem_addr_o !== 32'h10 || mem_wdata_o !== 0) begin
            tests_failed++;
            $display("FAIL fetch_issue: req/we/stall=%b addr=%h wdata=%h expected 101 00000010 0",
                     {mem_req_o, mem_we_o, stall_o}, mem_addr_o, mem_wdata_o);
        end
        repeat (2) @(negedge clk_i);
        tests_run++;
        if (mem_req_o !== 1'b1 || mem_addr_o !== 32'h10 || if_ack_o !== 1'b0) begin
            tests_failed++;
            $display("FAIL fetch_hold: req=%b addr=%h ack=%b expected 1 00000010 0",
                     mem_req_o, mem_addr_o, if_ack_o);
        end
        mem_ack_i = 1; mem_rdata_i = 32'h00A00093;
        @(negedge clk_i);
        mem_ack_i = 0;
        tests_run++;
        if (if_ack_o !== 1'b1 || if_rdata_o !== 32'h00A00093 || mem_req_o !== 1'b0 || stall_o !== 1'b0) begin
            tests_failed++;
            $display("FAIL fetch_ack: ack=%b rdata=%h req=%b stall=%b expected 1 00a00093 0 0",
                     if_ack_o, if_rdata_o, mem_req_o, stall_o);
        end
        if_req_i = 0;
        @(negedge clk_i);
        tests_run++;
        if (if_ack_o !== 1'b0 || if_rdata_o !== 32'h00A00093 || mem_req_o !== 1'b0) begin
            tests_failed++;
            $display("FAIL fetch_after: ack=%b rdata=%h req=%b expected 0 00a00093 0",
                     if_ack_o, if_rdata_o, mem_req_o);
        end
        $display("[TB] fetch 0x10 -> %h", if_rdata_o);
    endtask

    task automatic test_load_store();
        dm_req_i = 1; dm_we_i = 0; dm_addr_i = 32'h30;
        @(negedge clk_i);
        tests_run++;
        if (mem_req_o !== 1'b1 || mem_we_o !== 1'b0 || mem_addr_o !== 32'h30) begin
            tests_failed++;
            $display("FAIL load_issue: req=%b we=%b addr=%h expected 1 0 00000030",
                     mem_req_o, mem_we_o, mem_addr_o);
        end
        mem_ack_i = 1; mem_rdata_i = 32'h12345678;
        @(negedge clk_i);
        mem_ack_i = 0;
        tests_run++;
        if (dm_ack_o !== 1'b1 || dm_rdata_o !== 32'h12345678 || if_rdata_o !== 32'h00A00093 || if_ack_o !== 1'b0) begin
            tests_failed++;
            $display("FAIL load_ack: ack=%b rdata=%h if_rdata=%h if_ack=%b expected 1 12345678 00a00093 0",
                     dm_ack_o, dm_rdata_o, if_rdata_o, if_ack_o);
        end
        dm_req_i = 0;
        @(negedge clk_i);
        $display("[TB] load 0x30 -> %h", dm_rdata_o);

        dm_req_i = 1; dm_we_i = 1; dm_addr_i = 32'h20; dm_wdata_i = 32'hDEADBEEF;
        @(negedge clk_i);
        mem_rdata_i = 32'hFFFFFFFF;
        tests_run++;
        if (mem_req_o !== 1'b1 || mem_we_o !== 1'b1 || mem_addr_o !== 32'h20 || mem_wdata_o !== 32'hDEADBEEF) begin
            tests_failed++;
            $display("FAIL store_issue: req=%b we=%b addr=%h wdata=%h expected 1 1 00000020 deadbeef",
                     mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o);
        end
        dm_wdata_i = 32'h0; dm_addr_i = 32'h0;
        repeat (2) @(negedge clk_i);
        tests_run++;
        if (mem_req_o !== 1'b1 || mem_we_o !== 1'b1 || mem_addr_o !== 32'h20 || mem_wdata_o !== 32'hDEADBEEF) begin
            tests_failed++;
            $display("FAIL store_hold: req=%b we=%b addr=%h wdata=%h expected 1 1 00000020 deadbeef",
                     mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o);
        end
        mem_ack_i = 1;
        @(negedge clk_i);
        mem_ack_i = 0;
        tests_run++;
        if (dm_ack_o !== 1'b1 || dm_rdata_o !== 32'h0 || mem_req_o !== 1'b0) begin
            tests_failed++;
            $display("FAIL store_ack: ack=%b rdata=%h req=%b expected 1 00000000 0",
                     dm_ack_o, dm_rdata_o, mem_req_o);
        end
        dm_req_i = 0; dm_we_i = 0;
        @(negedge clk_i);
        tests_run++;
        if (dm_ack_o !== 1'b0) begin
            tests_failed++;
            $display("FAIL store_pulse: ack=%b expected 0", dm_ack_o);
        end
        $display("[TB] store 0x20 <- deadbeef");
    endtask

    task automatic test_starvation();
        logic [31:0] seq [6];
        logic [31:0] exp_seq [6];
        int n = 0;
        logic stall_bad = 0;
        exp_seq[0] = 32'h200; exp_seq[1] = 32'h200; exp_seq[2] = 32'h200;
        exp_seq[3] = 32'h200; exp_seq[4] = 32'h100; exp_seq[5] = 32'h200;
        if_req_i = 1; if_addr_i = 32'h100;
        dm_req_i = 1; dm_we_i = 0; dm_addr_i = 32'h200;
        mem_rdata_i = 32'h77;
        for (int cyc = 0; cyc < 100 && n < 6; cyc++) begin
            @(negedge clk_i);
            if (stall_o !== 1'b1) stall_bad = 1;
            if (mem_req_o) begin
                seq[n] = mem_addr_o;
                n++;
                mem_ack_i = 1;
            end else begin
                mem_ack_i = 0;
            end
        end
        @(negedge clk_i);
        mem_ack_i = 0; if_req_i = 0; dm_req_i = 0;
        tests_run++;
        if (n !== 6) begin
            tests_failed++;
            $display("FAIL starve_count: got %0d grants expected 6", n);
        end
        for (int i = 0; i < n; i++) begin
            tests_run++;
            if (seq[i] !== exp_seq[i]) begin
                tests_failed++;
                $display("FAIL starve_grant%0d: addr=%h expected %h", i, seq[i], exp_seq[i]);
            end
        end
        tests_run++;
        if (stall_bad !== 1'b0 || dm_rdata_o !== 32'h77) begin
            tests_failed++;
            $display("FAIL starve_stall: stall_dropped=%b dm_rdata=%h expected 0 00000077",
                     stall_bad, dm_rdata_o);
        end
        @(negedge clk_i);
        $display("[TB] starvation grants=%0d", n);
    endtask

    task automatic test_timeout();
        int busy = 0;
        logic seen = 0;
        dm_req_i = 1; dm_we_i = 0; dm_addr_i = 32'h40; mem_ack_i = 0;
        for (int cyc = 0; cyc < 400; cyc++) begin
            @(negedge clk_i);
            if (dm_ack_o) begin
                seen = 1;
                break;
            end
            if (mem_req_o) busy++;
        end
        tests_run++;
        if (seen !== 1'b1 || busy !== 255) begin
            tests_failed++;
            $display("FAIL timeout_len: acked=%b busy=%0d expected 1 255", seen, busy);
        end
        tests_run++;
        if (dm_rdata_o !== 32'h0 || err_o !== 1'b1 || mem_req_o !== 1'b0) begin
            tests_failed++;
            $display("FAIL timeout_ack: rdata=%h err=%b req=%b expected 00000000 1 0",
                     dm_rdata_o, err_o, mem_req_o);
        end
        dm_req_i = 0;
        repeat (2) @(negedge clk_i);
        tests_run++;
        if (err_o !== 1'b1 || dm_ack_o !== 1'b0) begin
            tests_failed++;
            $display("FAIL timeout_sticky: err=%b ack=%b expected 1 0", err_o, dm_ack_o);
        end
        if_req_i = 1; if_addr_i = 32'h44;
        @(negedge clk_i);
        mem_ack_i = 1; mem_rdata_i = 32'hCAFE0001;
        @(negedge clk_i);
        mem_ack_i = 0;
        tests_run++;
        if (if_ack_o !== 1'b1 || if_rdata_o !== 32'hCAFE0001 || err_o !== 1'b1) begin
            tests_failed++;
            $display("FAIL timeout_recover: ack=%b rdata=%h err=%b expected 1 cafe0001 1",
                     if_ack_o, if_rdata_o, err_o);
        end
        if_req_i = 0;
        @(negedge clk_i);
        $display("[TB] timeout busy=%0d err=%b", busy, err_o);
    endtask

    task automatic test_reset_mid();
        dm_req_i = 1; dm_we_i = 0; dm_addr_i = 32'h50;
        @(negedge clk_i);
        tests_run++;
        if (mem_req_o !== 1'b1 || mem_addr_o !== 32'h50) begin
            tests_failed++;
            $display("FAIL rstmid_issue: req=%b addr=%h expected 1 00000050", mem_req_o, mem_addr_o);
        end
        rst_i = 1; dm_req_i = 0;
        @(negedge clk_i);
        rst_i = 0;
        tests_run++;
        if (mem_req_o !== 1'b0 || dm_ack_o !== 1'b0 || err_o !== 1'b0 || mem_addr_o !== 32'h0) begin
            tests_failed++;
            $display("FAIL rstmid_abort: req=%b ack=%b err=%b addr=%h expected 0 0 0 00000000",
                     mem_req_o, dm_ack_o, err_o, mem_addr_o);
        end
        mem_ack_i = 1; mem_rdata_i = 32'h99;
        @(negedge clk_i);
        mem_ack_i = 0;
        @(negedge clk_i);
        tests_run++;
        if (dm_ack_o !== 1'b0 || if_ack_o !== 1'b0 || mem_req_o !== 1'b0 || dm_rdata_o !== 32'h0) begin
            tests_failed++;
            $display("FAIL rstmid_stray: dm_ack=%b if_ack=%b req=%b rdata=%h expected 0 0 0 00000000",
                     dm_ack_o, if_ack_o, mem_req_o, dm_rdata_o);
        end
        $display("[TB] reset mid-transaction, stray ack ignored");
    endtask

    task automatic test_ack_at_timeout();
        int busy = 0;
        dm_req_i = 1; dm_we_i = 0; dm_addr_i = 32'h60; mem_ack_i = 0;
        for (int cyc = 0; cyc < 400; cyc++) begin
            @(negedge clk_i);
            if (mem_req_o) begin
                busy++;
                if (busy == 255) begin
                    mem_ack_i = 1; mem_rdata_i = 32'h5;
                    break;
                end
            end
        end
        @(negedge clk_i);
        mem_ack_i = 0;
        tests_run++;
        if (busy !== 255 || dm_ack_o !== 1'b1 || dm_rdata_o !== 32'h5 || err_o !== 1'b0) begin
            tests_failed++;
            $display("FAIL ack_at_timeout: busy=%0d ack=%b rdata=%h err=%b expected 255 1 00000005 0",
                     busy, dm_ack_o, dm_rdata_o, err_o);
        end
        dm_req_i = 0;
        @(negedge clk_i);
        $display("[TB] ack on last busy cycle -> %h err=%b", dm_rdata_o, err_o);
    endtask

    initial begin
        test_reset();
        test_fetch();
        test_load_store();
        test_starvation();
        test_timeout();
        test_reset_mid();
        test_ack_at_timeout();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
